rx_packet_parser: RTL and testbench
===================================

// Module: rx_packet_parser
// PURPOSE
//  Upstream feeder for learnCosts. Accepts 16-bit words from the radio RX FIFO (valid/ready), frames
//  fixed-length packets and extracts source ID, battery status, value and cluster ID.
//  Issues a one-cycle learn_en to learnCosts, then holds off new input until learn_done or timeout.
//  Drops non-data packets and self-originated packets.
// PARAMETERS
//  WORD_WIDTH    16   data/field width
//  DATA_TYPE     4'h1 header[15:12] code for a data packet
//  DONE_TIMEOUT  255  max cycles in WAIT_DONE before abandoning; 8-bit counter
//  CNT_WIDTH     8    width of pkt_count / drop_count
// PORTS
//  clock         in   1     system clock, rising edge
//  nrst          in   1     asynchronous active-low reset
//  my_id         in   16    own node ID (static)
//  rx_valid      in   1     rx_data valid
//  rx_data       in   16    incoming packet word
//  rx_ready      out  1     word accepted when rx_valid & rx_ready
//  fsourceID     out  16    parsed source ID to learnCosts
//  fbatteryStat  out  16    parsed battery status
//  fValue        out  16    parsed value
//  fclusterID    out  16    parsed cluster ID
//  learn_en      out  1     one-cycle start pulse to learnCosts
//  learn_done    in   1     learnCosts done
//  busy          out  1     high in ISSUE/WAIT_DONE
//  pkt_count     out  8     packets issued (wraps 255->0)
//  drop_count    out  8     packets dropped or timed out (wraps)
// BEHAVIOUR
//  Reset: state=IDLE, rx_ready=0 for the reset cycle then 1, all field outputs 0, learn_en=0, busy=0, counters 0.
//  Packet: W0 header, W1 src, W2 battery, W3 value, W4 cluster [, W5 checksum if CHECKSUM_EN].
//  States: IDLE -> SRC -> BAT -> VAL -> CLU [-> CHK] -> ISSUE -> WAIT_DONE -> IDLE; also DISCARD.
//  Each receive state advances only on handshake (rx_valid & rx_ready); rx_ready=1 in all receive
//   states and DISCARD, 0 in ISSUE/WAIT_DONE.
//  IDLE: header[15:12]!=DATA_TYPE -> DISCARD; consumes the remaining 4 (5) words, drop_count++, -> IDLE.
//  Fields captured into shadow regs; outputs updated only on entry to ISSUE, held stable until next ISSUE.
//  After the last word, drop if src==my_id (or checksum bad): drop_count++, -> IDLE, outputs unchanged.
//  Otherwise -> ISSUE: learn_en=1 for exactly one cycle, the cycle after the last-word handshake; pkt_count++.
//  WAIT_DONE: learn_done -> IDLE next cycle; timeout after DONE_TIMEOUT cycles -> IDLE, drop_count++.
//  learn_done during ISSUE is honoured, same as in WAIT_DONE; learn_done outside ISSUE/WAIT_DONE is ignored.
//  Counters saturate? No: modulo-2^8 wrap.
//  Reset mid-packet: partial packet discarded, return to reset values; no learn_en issued.
//  rx_valid low mid-packet: state holds indefinitely (no inter-word timeout).
// CONFIGURATION
//  CHECKSUM_EN defined:
//   - 6-word packet.
//   - W5 must equal XOR of W0..W4; on mismatch the packet is dropped and drop_count increments.
//  CHECKSUM_EN undefined:
//   - 5-word packet; no checksum state.
//   - DISCARD consumes 4 words.
// TESTING
//  1. Words 1000,001F,0005,000A,000B, my_id=1, learn_done 3 cycles after learn_en -> one learn_en pulse.
//     Outputs 31/5/10/11; pkt_count=1; busy 1->0.
//  2. Header 2000 + 4 words -> no learn_en; drop_count=1; outputs stay 0; rx_ready stays 1.
//  3. src=0001 with my_id=1 -> dropped; drop_count=1; next valid packet issues normally.
//  4. learn_done never asserted -> busy for 255 cycles, then IDLE; drop_count=1; rx_ready returns to 1.
//  5. nrst low after W2 -> all outputs 0; the following full packet parses correctly with learn_en once.
//  6. CHECKSUM_EN: W5=XOR ok -> issued; W5 off by one -> dropped, drop_count++.
//     rx_valid gaps between words -> same result.

Source files
------------

// File: rtl/rx_packet_parser.sv
// rx_packet_parser: frames fixed-length packets from the radio RX FIFO and hands their fields to learnCosts.
// Define CHECKSUM_EN for 6-word packets whose last word is the XOR of the first five.
module rx_packet_parser #(
    parameter int unsigned WORD_WIDTH   = 16,
    parameter logic [3:0]  DATA_TYPE    = 4'h1,
    parameter int unsigned DONE_TIMEOUT = 255,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] my_id,
    input  logic                  rx_valid,
    input  logic [WORD_WIDTH-1:0] rx_data,
    output logic                  rx_ready,
    output logic [WORD_WIDTH-1:0] fsourceID,
    output logic [WORD_WIDTH-1:0] fbatteryStat,
    output logic [WORD_WIDTH-1:0] fValue,
    output logic [WORD_WIDTH-1:0] fclusterID,
    output logic                  learn_en,
    input  logic                  learn_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SRC,
        S_BAT,
        S_VAL,
        S_CLU,
`ifdef CHECKSUM_EN
        S_CHK,
`endif
        S_ISSUE,
        S_WAIT_DONE,
        S_DISCARD
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(DONE_TIMEOUT - 1);
`ifdef CHECKSUM_EN
    localparam logic [2:0] DISCARD_WORDS = 3'd5;
`else
    localparam logic [2:0] DISCARD_WORDS = 3'd4;
`endif

    state_t                r_state;
    logic                  r_rx_ready;
    logic                  r_learn_en;
    logic                  r_busy;
    logic [WORD_WIDTH-1:0] r_src;
    logic [WORD_WIDTH-1:0] r_bat;
    logic [WORD_WIDTH-1:0] r_val;
    logic [WORD_WIDTH-1:0] r_fsrc;
    logic [WORD_WIDTH-1:0] r_fbat;
    logic [WORD_WIDTH-1:0] r_fval;
    logic [WORD_WIDTH-1:0] r_fclu;
    logic [CNT_WIDTH-1:0]  r_pkt_count;
    logic [CNT_WIDTH-1:0]  r_drop_count;
    logic [7:0]            r_timer;
    logic [2:0]            r_disc_left;

    logic                  w_hs;
    logic                  w_drop;
    logic [WORD_WIDTH-1:0] w_clu;

    assign w_hs = rx_valid & r_rx_ready;

`ifdef CHECKSUM_EN
    logic [WORD_WIDTH-1:0] r_csum;
    logic [WORD_WIDTH-1:0] r_clu;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_csum <= '0;
            r_clu  <= '0;
        end else if (w_hs) begin
            r_csum <= (r_state == S_IDLE) ? rx_data : (r_csum ^ rx_data);
            if (r_state == S_CLU)
                r_clu <= rx_data;
        end
    end

    assign w_drop = (r_src == my_id) || (rx_data != r_csum);
    assign w_clu  = r_clu;
`else
    assign w_drop = (r_src == my_id);
    assign w_clu  = rx_data;
`endif

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_rx_ready   <= 1'b0;
            r_learn_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_src        <= '0;
            r_bat        <= '0;
            r_val        <= '0;
            r_fsrc       <= '0;
            r_fbat       <= '0;
            r_fval       <= '0;
            r_fclu       <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
            r_timer      <= '0;
            r_disc_left  <= '0;
        end else begin
            r_learn_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_rx_ready <= 1'b1;
                    if (w_hs) begin
                        if (rx_data[WORD_WIDTH-1 -: 4] == DATA_TYPE) begin
                            r_state <= S_SRC;
                        end else begin
                            r_disc_left <= DISCARD_WORDS;
                            r_state     <= S_DISCARD;
                        end
                    end
                end
                S_SRC: if (w_hs) begin
                    r_src   <= rx_data;
                    r_state <= S_BAT;
                end
                S_BAT: if (w_hs) begin
                    r_bat   <= rx_data;
                    r_state <= S_VAL;
                end
                S_VAL: if (w_hs) begin
                    r_val   <= rx_data;
                    r_state <= S_CLU;
                end
`ifdef CHECKSUM_EN
                S_CLU: if (w_hs) r_state <= S_CHK;
                S_CHK: begin
`else
                S_CLU: begin
`endif
                    // last word of the packet: either drop it or publish all fields at once
                    if (w_hs) begin
                        if (w_drop) begin
                            r_drop_count <= r_drop_count + 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_fsrc      <= r_src;
                            r_fbat      <= r_bat;
                            r_fval      <= r_val;
                            r_fclu      <= w_clu;
                            r_learn_en  <= 1'b1;
                            r_busy      <= 1'b1;
                            r_rx_ready  <= 1'b0;
                            r_pkt_count <= r_pkt_count + 1'b1;
                            r_timer     <= '0;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE, S_WAIT_DONE: begin
                    // the timeout window covers the ISSUE cycle too, so busy lasts at most DONE_TIMEOUT cycles
                    if (learn_done) begin
                        r_busy     <= 1'b0;
                        r_rx_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (r_timer == TIMER_LAST) begin
                        r_busy       <= 1'b0;
                        r_rx_ready   <= 1'b1;
                        r_drop_count <= r_drop_count + 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_DISCARD: if (w_hs) begin
                    if (r_disc_left == 3'd1) begin
                        r_drop_count <= r_drop_count + 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_disc_left <= r_disc_left - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_ready     = r_rx_ready;
    assign learn_en     = r_learn_en;
    assign busy         = r_busy;
    assign fsourceID    = r_fsrc;
    assign fbatteryStat = r_fbat;
    assign fValue       = r_fval;
    assign fclusterID   = r_fclu;
    assign pkt_count    = r_pkt_count;
    assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Bench for rx_packet_parser: packet-level reference model plus directed and random packets.
// Build with CHECKSUM_EN defined to exercise the 6-word checksum variant.
module tb_rx_packet_parser;

    localparam int DONE_TIMEOUT = 255;
`ifdef CHECKSUM_EN
    localparam int PKT_LEN = 6;
`else
    localparam int PKT_LEN = 5;
`endif

    logic        clock = 1'b0;
    logic        nrst  = 1'b0;
    logic [15:0] my_id = 16'h0001;
    logic        rx_valid = 1'b0;
    logic [15:0] rx_data  = '0;
    logic        rx_ready;
    logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID;
    logic        learn_en;
    logic        learn_done = 1'b0;
    logic        busy;
    logic [7:0]  pkt_count, drop_count;

    rx_packet_parser #(
        .WORD_WIDTH  (16),
        .DATA_TYPE   (4'h1),
        .DONE_TIMEOUT(255),
        .CNT_WIDTH   (8)
    ) dut (
        .clock       (clock),
        .nrst        (nrst),
        .my_id       (my_id),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .fsourceID   (fsourceID),
        .fbatteryStat(fbatteryStat),
        .fValue      (fValue),
        .fclusterID  (fclusterID),
        .learn_en    (learn_en),
        .learn_done  (learn_done),
        .busy        (busy),
        .pkt_count   (pkt_count),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int learn_pulses = 0;
    int busy_cnt = 0;
    int done_delay = 1000;
    bit spur_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words are collected per packet and judged only when the packet is complete.
    logic [15:0] m_q[$];
    logic        m_ready, m_busy, m_learn;
    int          m_nb;
    logic [15:0] m_src, m_bat, m_val, m_clu;
    logic [7:0]  m_pkt, m_drop;

    function automatic bit pkt_ok(input logic [15:0] id);
        logic [15:0] x;
        if (m_q[0][15:12] != 4'h1) return 1'b0;
        if (m_q[1] == id) return 1'b0;
        x = m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3] ^ m_q[4];
        if (PKT_LEN == 6 && m_q[PKT_LEN-1] != x) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ready = 1'b0; m_busy = 1'b0; m_learn = 1'b0; m_nb = 0;
        m_src = '0; m_bat = '0; m_val = '0; m_clu = '0;
        m_pkt = '0; m_drop = '0;
    endtask

    task automatic model_step();
        logic old_ready;
        old_ready = m_ready;
        m_learn = 1'b0;
        if (m_busy) begin
            m_nb++;
            if (learn_done) m_busy = 1'b0;
            else if (m_nb == DONE_TIMEOUT) begin
                m_busy = 1'b0;
                m_drop = m_drop + 8'd1;
            end
        end else if (rx_valid && old_ready) begin
            m_q.push_back(rx_data);
            if (m_q.size() == PKT_LEN) begin
                if (pkt_ok(my_id)) begin
                    m_src = m_q[1]; m_bat = m_q[2]; m_val = m_q[3]; m_clu = m_q[4];
                    m_busy = 1'b1; m_learn = 1'b1; m_nb = 0;
                    m_pkt = m_pkt + 8'd1;
                end else begin
                    m_drop = m_drop + 8'd1;
                end
                m_q.delete();
            end
        end
        m_ready = !m_busy;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge nrst);
            if (!nrst) model_reset();
            else model_step();
        end
    end

    // learnCosts stand-in: answers done_delay cycles after learn_en, plus stray pulses while idle
    initial forever begin
        @(negedge clock);
        if (m_busy) learn_done = (m_nb == done_delay);
        else learn_done = spur_en && ($urandom_range(0, 7) == 0);
    end

    initial forever begin
        @(posedge clock);
        #2;
        check("rx_ready", 32'(rx_ready), 32'(m_ready));
        check("learn_en", 32'(learn_en), 32'(m_learn));
        check("busy", 32'(busy), 32'(m_busy));
        check("fsourceID", 32'(fsourceID), 32'(m_src));
        check("fbatteryStat", 32'(fbatteryStat), 32'(m_bat));
        check("fValue", 32'(fValue), 32'(m_val));
        check("fclusterID", 32'(fclusterID), 32'(m_clu));
        check("pkt_count", 32'(pkt_count), 32'(m_pkt));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        if (learn_en) learn_pulses++;
        if (busy) busy_cnt++;
    end

    task automatic send_word(input logic [15:0] w, input int gap);
        logic rdy;
        int   n;
        for (int i = 0; i < gap; i++) begin
            @(negedge clock);
            rx_valid = 1'b0;
            rx_data  = 16'($urandom);
        end
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = w;
        n = 0;
        forever begin
            rdy = rx_ready;
            @(posedge clock);
            if (rdy) break;
            n++;
            if (n > 2000) begin
                n_cmp++; n_bad++;
                $display("FAIL handshake_timeout: got no rx_ready expected within 2000 cycles");
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic send_pkt(input logic [15:0] h, input logic [15:0] s, input logic [15:0] b,
                            input logic [15:0] v, input logic [15:0] c, input bit corrupt,
                            input int gapmax);
        logic [15:0] w[6];
        w[0] = h; w[1] = s; w[2] = b; w[3] = v; w[4] = c;
        w[5] = h ^ s ^ b ^ v ^ c;
        if (corrupt) w[5] = w[5] + 16'd1;
        for (int i = 0; i < PKT_LEN; i++)
            send_word(w[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(posedge clock);
            #3;
            if (!m_busy && m_q.size() == 0) break;
            n++;
            if (n > 1000) begin
                n_cmp++; n_bad++;
                $display("FAIL idle_timeout: got busy expected idle within 1000 cycles");
                break;
            end
        end
        repeat (2) @(posedge clock);
    endtask

    task automatic do_reset(input logic [15:0] id);
        @(negedge clock);
        nrst = 1'b0;
        rx_valid = 1'b0;
        my_id = id;
        repeat (2) @(negedge clock);
        nrst = 1'b1;
        learn_pulses = 0;
        busy_cnt = 0;
        repeat (2) @(negedge clock);
    endtask

    logic [15:0] h, s;
    bit          cor;

    initial begin
        repeat (3) @(negedge clock);
        check("reset_rx_ready", 32'(rx_ready), 32'd0);
        check("reset_pkt_count", 32'(pkt_count), 32'd0);
        nrst = 1'b1;

        // 1: one clean packet, learn_done three cycles after learn_en
        do_reset(16'h0001);
        done_delay = 3;
        send_pkt(16'h1000, 16'h001F, 16'h0005, 16'h000A, 16'h000B, 1'b0, 0);
        wait_idle();
        check("t1_src", 32'(fsourceID), 32'd31);
        check("t1_bat", 32'(fbatteryStat), 32'd5);
        check("t1_val", 32'(fValue), 32'd10);
        check("t1_clu", 32'(fclusterID), 32'd11);
        check("t1_pkt", 32'(pkt_count), 32'd1);
        check("t1_pulses", 32'(learn_pulses), 32'd1);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd4);

        // 2: non-data header is discarded
        do_reset(16'h0001);
        send_pkt(16'h2000, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 1'b0, 0);
        wait_idle();
        check("t2_drop", 32'(drop_count), 32'd1);
        check("t2_src", 32'(fsourceID), 32'd0);
        check("t2_pulses", 32'(learn_pulses), 32'd0);
        check("t2_ready", 32'(rx_ready), 32'd1);

        // 3: self-originated packet dropped, next one issues
        do_reset(16'h0001);
        done_delay = 0;
        send_pkt(16'h1000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0, 0);
        wait_idle();
        check("t3_drop", 32'(drop_count), 32'd1);
        check("t3_pkt0", 32'(pkt_count), 32'd0);
        send_pkt(16'h1ABC, 16'h0022, 16'h0002, 16'h0003, 16'h0004, 1'b0, 0);
        wait_idle();
        check("t3_pkt1", 32'(pkt_count), 32'd1);
        check("t3_src", 32'(fsourceID), 32'h22);

        // 4: learn_done never arrives
        do_reset(16'h0001);
        done_delay = 1000;
        send_pkt(16'h1000, 16'h0077, 16'h0001, 16'h0002, 16'h0003, 1'b0, 0);
        wait_idle();
        check("t4_busy_cycles", 32'(busy_cnt), 32'd255);
        check("t4_drop", 32'(drop_count), 32'd1);
        check("t4_ready", 32'(rx_ready), 32'd1);

        // 5: reset after W2 abandons the partial packet
        do_reset(16'h0001);
        done_delay = 2;
        send_pkt(16'h1000, 16'h0099, 16'h0001, 16'h0002, 16'h0003, 1'b0, 0);
        wait_idle();
        send_word(16'h1000, 0);
        send_word(16'h0055, 0);
        send_word(16'h0066, 0);
        do_reset(16'h0001);
        check("t5_src0", 32'(fsourceID), 32'd0);
        check("t5_pkt0", 32'(pkt_count), 32'd0);
        send_pkt(16'h1000, 16'h0042, 16'h0007, 16'h0008, 16'h0009, 1'b0, 0);
        wait_idle();
        check("t5_pulses", 32'(learn_pulses), 32'd1);
        check("t5_src", 32'(fsourceID), 32'h42);

`ifdef CHECKSUM_EN
        // 6: checksum good then off by one, without and with gaps
        do_reset(16'h0001);
        done_delay = 1;
        send_pkt(16'h1000, 16'h001F, 16'h0005, 16'h000A, 16'h000B, 1'b0, 0);
        wait_idle();
        send_pkt(16'h1000, 16'h001F, 16'h0005, 16'h000A, 16'h000B, 1'b1, 0);
        wait_idle();
        check("t6_pkt", 32'(pkt_count), 32'd1);
        check("t6_drop", 32'(drop_count), 32'd1);
        send_pkt(16'h1000, 16'h001F, 16'h0005, 16'h000A, 16'h000B, 1'b0, 3);
        wait_idle();
        send_pkt(16'h1000, 16'h001F, 16'h0005, 16'h000A, 16'h000B, 1'b1, 3);
        wait_idle();
        check("t6_pkt_gap", 32'(pkt_count), 32'd2);
        check("t6_drop_gap", 32'(drop_count), 32'd2);
`endif

        // random packets with gaps, stray learn_done and occasional timeouts
        do_reset(16'($urandom_range(1, 65535)));
        spur_en = 1'b1;
        for (int k = 0; k < 120; k++) begin
            h = ($urandom_range(0, 99) < 85) ? {4'h1, 12'($urandom)}
                                              : {4'((1 + $urandom_range(1, 15)) % 16), 12'($urandom)};
            s = ($urandom_range(0, 4) == 0) ? my_id : 16'($urandom);
            done_delay = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 6));
            cor = ($urandom_range(0, 3) == 0);
            send_pkt(h, s, 16'($urandom), 16'($urandom), 16'($urandom), cor, 2);
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
